// File: rtl/mux_sel_sequencer.sv
// Operand register stage with a debounced / auto-toggling / forced select
// for a downstream 2:1 mux.
module mux_sel_sequencer #(
  parameter int W       = 4,
  parameter int DEB_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [1:0]   mode,
  input  logic         sel_btn,
  input  logic [3:0]   period,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q,
  output logic         sel,
  output logic         sel_pulse,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    WAIT_REL
  } st_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

  st_t        state;
  logic [3:0] deb_cnt;
  logic [3:0] tick_cnt;
  logic [1:0] mode_q;
  logic       sync1;
  logic       btn_s;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sel       <= 1'b0;
      sel_pulse <= 1'b0;
      state     <= IDLE;
      deb_cnt   <= 4'd0;
      tick_cnt  <= 4'd0;
      mode_q    <= 2'b00;
      sync1     <= 1'b0;
      btn_s     <= 1'b0;
    end else if (ena) begin
      a_q       <= a_in;
      b_q       <= b_in;
      sync1     <= sel_btn;
      btn_s     <= sync1;
      mode_q    <= mode;
      sel_pulse <= 1'b0;
      if (mode != mode_q) begin
        // a mode switch restarts everything; only force-zero acts at once
        state    <= IDLE;
        deb_cnt  <= 4'd0;
        tick_cnt <= 4'd0;
        if (mode == 2'b11) begin
          sel       <= 1'b0;
          sel_pulse <= sel;
        end
      end else begin
        unique case (mode)
          2'b00: begin
            tick_cnt <= 4'd0;
            unique case (state)
              IDLE: begin
                if (btn_s) begin
                  state   <= DEB;
                  deb_cnt <= 4'd1;
                end else begin
                  deb_cnt <= 4'd0;
                end
              end
              DEB: begin
                if (!btn_s) begin
                  state   <= IDLE;
                  deb_cnt <= 4'd0;
                end else if (deb_cnt == DEB_LAST) begin
                  sel       <= ~sel;
                  sel_pulse <= 1'b1;
                  state     <= WAIT_REL;
                  deb_cnt   <= 4'd0;
                end else begin
                  deb_cnt <= deb_cnt + 4'd1;
                end
              end
              WAIT_REL: begin
                if (!btn_s) state <= IDLE;
              end
              default: begin
                state   <= IDLE;
                deb_cnt <= 4'd0;
              end
            endcase
          end
          2'b01: begin
            state   <= IDLE;
            deb_cnt <= 4'd0;
            if (tick_cnt >= period) begin
              sel       <= ~sel;
              sel_pulse <= 1'b1;
              tick_cnt  <= 4'd0;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          2'b10: begin
            state    <= IDLE;
            deb_cnt  <= 4'd0;
            tick_cnt <= 4'd0;
          end
          2'b11: begin
            state     <= IDLE;
            deb_cnt   <= 4'd0;
            tick_cnt  <= 4'd0;
            sel       <= 1'b0;
            sel_pulse <= sel;
          end
        endcase
      end
    end else begin
      sel_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: fixed vectors, directed corner sequences
// and random traffic against a run-length reference model.
module tb_mux_sel_sequencer;

  localparam int W   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [1:0]   mode;
  logic         sel_btn;
  logic [3:0]   period;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         sel;
  logic         sel_pulse;
  logic         busy;

  mux_sel_sequencer #(.W(W), .DEB_CYC(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .mode      (mode),
    .sel_btn   (sel_btn),
    .period    (period),
    .a_in      (a_in),
    .b_in      (b_in),
    .a_q       (a_q),
    .b_q       (b_q),
    .sel       (sel),
    .sel_pulse (sel_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: a press is a run of synchronized-high samples
  int   m_s1, m_s2, m_mode_q, m_run, m_tick;
  int   m_sel, m_pulse, m_a, m_b;
  bit   use_model;

  task automatic model_edge();
    int old_sel;
    int nsel;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_mode_q = 0; m_run = 0; m_tick = 0;
      m_sel = 0; m_pulse = 0; m_a = 0; m_b = 0;
    end else if (ena) begin
      old_sel = m_sel;
      nsel = old_sel;
      if (int'(mode) != m_mode_q) begin
        m_run = 0;
        m_tick = 0;
        if (mode == 2'd3) nsel = 0;
      end else if (mode == 2'd0) begin
        m_tick = 0;
        if (m_s2 != 0) begin
          m_run++;
          if (m_run == DEB) nsel = 1 - old_sel;
        end else begin
          m_run = 0;
        end
      end else if (mode == 2'd1) begin
        m_run = 0;
        if (m_tick >= int'(period)) begin
          nsel = 1 - old_sel;
          m_tick = 0;
        end else begin
          m_tick++;
        end
      end else begin
        m_run = 0;
        m_tick = 0;
        if (mode == 2'd3) nsel = 0;
      end
      m_pulse = (nsel != old_sel) ? 1 : 0;
      m_sel = nsel;
      m_mode_q = int'(mode);
      m_s2 = m_s1;
      m_s1 = int'(sel_btn);
      m_a = int'(a_in);
      m_b = int'(b_in);
    end else begin
      m_pulse = 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic bt, input logic [3:0] p,
                      input logic [3:0] a, input logic [3:0] b);
    rst = r; ena = e; mode = m; sel_btn = bt; period = p;
    a_in = a; b_in = b;
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) begin
      chk("model a_q", int'(a_q), m_a);
      chk("model b_q", int'(b_q), m_b);
      chk("model sel", int'(sel), m_sel);
      chk("model sel_pulse", int'(sel_pulse), m_pulse);
      chk("model busy", int'(busy), (m_run > 0) ? 1 : 0);
    end
  endtask

  typedef struct {
    logic       r, e;
    logic [1:0] m;
    logic       bt;
    logic [3:0] a, b;
    logic [3:0] ea, eb;
    logic       esel, ep, ebusy;
  } vec_t;

  vec_t tbl[15];
  int   np;
  logic s0;

  initial begin
    rst = 1'b1; ena = 1'b0; mode = 2'b00; sel_btn = 1'b0;
    period = 4'd0; a_in = '0; b_in = '0;
    use_model = 1'b0;
    #2;
    //        r     e     m      bt    a      b      ea     eb   sel   p  busy
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h3, 4'hC, 4'h3, 4'hC, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h5, 4'hA, 4'h5, 4'hA, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h1, 4'h2, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h1, 4'h2, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h7, 4'h8, 4'h7, 4'h8, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h9, 4'h6, 4'h9, 4'h6, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h9, 4'h6, 4'h9, 4'h6, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'hF, 4'hF, 4'h9, 4'h6, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 4'h4, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'hB, 4'hD, 4'hB, 4'hD, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'hB, 4'hD, 4'hB, 4'hD, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 2'd3, 1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'd3, 1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].bt, 4'd0, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d a_q", i), int'(a_q), int'(tbl[i].ea));
      chk($sformatf("vec%0d b_q", i), int'(b_q), int'(tbl[i].eb));
      chk($sformatf("vec%0d sel", i), int'(sel), int'(tbl[i].esel));
      chk($sformatf("vec%0d sel_pulse", i), int'(sel_pulse), int'(tbl[i].ep));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].ebusy));
    end

    use_model = 1'b1;

    // long hold: exactly one toggle per press
    step(1, 1, 0, 0, 0, 0, 0);
    np = 0;
    for (int i = 0; i < 25; i++) begin
      step(0, 1, 0, 1, 0, 4'(i), 4'(i + 1));
      if (sel_pulse) np++;
    end
    chk("hold pulses", np, 1);
    chk("hold sel", int'(sel), 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 2);
    chk("release busy", int'(busy), 0);

    // bounce shorter than the debounce window
    step(1, 1, 0, 0, 0, 0, 0);
    np = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, (i < 3) ? 1'b1 : 1'b0, 0, 3, 3);
      if (sel_pulse) np++;
    end
    chk("bounce sel", int'(sel), 0);
    chk("bounce busy", int'(busy), 0);
    chk("bounce pulses", np, 0);

    // auto-toggle
    step(0, 1, 1, 0, 2, 0, 0);
    chk("mode change no toggle", int'(sel_pulse), 0);
    np = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 1, 0, 2, 0, 0);
      if (sel_pulse) np++;
    end
    chk("period2 toggles", np, 3);
    np = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 0, 0, 0);
      if (sel_pulse) np++;
    end
    chk("period0 toggles", np, 5);
    step(0, 1, 1, 0, 2, 0, 0);
    s0 = sel;
    np = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 2, 4'hF, 4'hF);
      if (sel_pulse) np++;
    end
    chk("freeze pulses", np, 0);
    chk("freeze sel", int'(sel), int'(s0));
    step(0, 1, 1, 0, 2, 0, 0);
    chk("resume tick1", int'(sel_pulse), 0);
    step(0, 1, 1, 0, 2, 0, 0);
    chk("resume tick2", int'(sel_pulse), 1);

    // force-zero from sel=1
    for (int i = 0; i < 2 && sel != 1'b1; i++) step(0, 1, 1, 0, 0, 0, 0);
    chk("pre force sel", int'(sel), 1);
    step(0, 1, 3, 0, 0, 0, 0);
    chk("force sel", int'(sel), 0);
    chk("force pulse", int'(sel_pulse), 1);

    // reset abandons a debounce in progress
    step(0, 1, 0, 0, 0, 0, 0);
    np = 0;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0, 0);
    chk("mid-deb busy", int'(busy), 1);
    step(1, 1, 0, 1, 0, 0, 0);
    chk("rst busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, (i < 2) ? 1'b1 : 1'b0, 0, 0, 0);
      if (sel_pulse) np++;
    end
    chk("rst deb sel", int'(sel), 0);
    chk("rst deb pulses", np, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r, e, bt;
      logic [1:0] m;
      logic [3:0] p;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 7) != 0);
      m  = ($urandom_range(0, 39) == 0) ? 2'($urandom) : mode;
      bt = ($urandom_range(0, 11) == 0) ? ~sel_btn : sel_btn;
      p  = ($urandom_range(0, 29) == 0) ? 4'($urandom) : period;
      step(r, e, m, bt, p, 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
